// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback select pipeline.
//   DATA_W / ADDR_W : default result width and register-file address width
//   ZERO_REG        : architectural zero register (writes are suppressed)
//   wb_entry_t      : one writeback entry (data, destination, write enable)
package wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } wb_entry_t;
endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: two-entry valid/ready buffer (main + skid), generic over width.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_data_o always shows main
// in_ready_o comes straight from a flop, so out_ready_i never reaches it
// combinationally.
module wb_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         main_valid_q;
  logic         skid_valid_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         drain;

  assign accept = in_valid_i & ~skid_valid_q;
  assign drain  = main_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else if (drain) begin
      // Skid full implies no accept this cycle (in_ready was low).
      if (skid_valid_q) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_q <= in_data_i;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_q       <= in_data_i;
        skid_valid_q <= 1'b1;
      end else begin
        main_q       <= in_data_i;
        main_valid_q <= 1'b1;
      end
    end
  end

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
endmodule

// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: registered writeback source selector with a two-entry skid
// buffer between the MEM/WB register and the register-file write port.
//   clk, reset_n             : clock, asynchronous active-low reset
//   in_valid/in_ready        : upstream handshake
//   src_data, sel            : flattened candidate results and source index
//   in_addr, in_we           : destination register and write request
//   out_valid/out_ready      : downstream handshake
//   wb_data, wb_addr, wb_we  : registered head entry (wb_we qualified by valid)
//   sel_err                  : sticky flag, set by accepting an out-of-range sel
module wb_sel_pipe #(
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int ADDR_W  = wb_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic                      in_we,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         wb_data,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic                      wb_we,
  output logic                      sel_err
);
  import wb_pkg::*;

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [DATA_W-1:0]  sel_data;
  logic               sel_oor;
  logic               accept;
  logic               sel_err_q;
  entry_t             in_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // An out-of-range sel matches no source, so the mux naturally yields 0.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
    end
  end

  assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));
  assign accept  = in_valid & in_ready;

  always_comb begin
    in_entry.data = sel_data;
    in_entry.addr = in_addr;
    // Writes to the zero register are dropped but the entry still flows.
    in_entry.we   = in_we & (in_addr != ADDR_W'(ZERO_REG));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               sel_err_q <= 1'b0;
    else if (accept && sel_oor) sel_err_q <= 1'b1;
  end

  wb_skid_buf #(.W(ENTRY_W)) u_buf (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head_bits)
  );

  assign head_entry = entry_t'(head_bits);
  assign wb_data    = head_entry.data;
  assign wb_addr    = head_entry.addr;
  assign wb_we      = head_entry.we & out_valid;
  assign sel_err    = sel_err_q;
endmodule

// File: doc/wb_sel_pipe.md
# wb_sel_pipe

Parametrised, registered successor to the writeback source selector. Chooses one of `NUM_SRC` result words per instruction and registers it together with destination register and write enable. A two-entry skid buffer with a valid/ready handshake lets the writeback stage stall without losing data. Sits between the MEM/WB pipeline register and the register-file write port, and exports the registered result as a forwarding source.

## Interface
- `DATA_W`, 32, result word width
- `NUM_SRC`, 4, number of candidate sources (≥2)
- `SEL_W`, `$clog2(NUM_SRC)`, select width (derived; do not override)
- `ADDR_W`, 5, register-file address width
- `clk` input 1 — single clock, rising edge
- `reset_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — upstream presents an instruction
- `in_ready` output 1 — block can accept this cycle
- `src_data` input `NUM_SRC*DATA_W` — flattened sources; source k at bits `[k*DATA_W +: DATA_W]`
- `sel` input `SEL_W` — source index
- `in_addr` input `ADDR_W` — destination register
- `in_we` input 1 — instruction writes a register
- `out_valid` output 1 — registered writeback present
- `out_ready` input 1 — register file / downstream accepts
- `wb_data` output `DATA_W` — selected word
- `wb_addr` output `ADDR_W` — destination register
- `wb_we` output 1 — qualified write enable
- `sel_err` output 1 — sticky out-of-range select flag

## Operation
- Accept: transfer when `in_valid && in_ready`. Capture `src_data[sel]`, `in_addr`, and `in_we` qualified as below.
- Out-of-range `sel` (`sel >= NUM_SRC`, only possible for non-power-of-2 `NUM_SRC`):
  - Captured data is 0.
  - `sel_err` sets on that accept and stays set until reset.
- Register-0 write: an `in_addr` of 0 forces the captured `we` to 0. Data and address are still carried.
- Output: `wb_we` is the captured `we` ANDed with `out_valid`. `wb_data` and `wb_addr` hold the current head entry.
- Storage has two entries, main and skid. The output always drives main.
- Drain: a transfer out happens when `out_valid && out_ready`.
  - If skid is full, skid moves to main.
  - Otherwise main empties, unless an accept fills it in the same cycle.
- `in_ready` is the inverse of skid-full and is a registered flag, so there is no combinational path from `out_ready`.
- Accept while main is full and no drain occurs: the entry goes to skid.
- Accept while main is full and a drain occurs: the entry goes directly to main.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: accept at edge N gives `out_valid`=1 and the data visible after edge N (registered, 1 cycle).
- Throughput: 1 per cycle while `out_ready`=1.
- Occupancy 0 to 2.
  - `in_ready`=0 exactly when occupancy is 2.
  - `in_ready` returns to 1 the cycle after the first drain from full.
- Simultaneous accept and drain at occupancy 1 keeps occupancy at 1, with main replaced by the new entry.
- Simultaneous accept and drain at occupancy 2 is impossible, because `in_ready`=0.
- Reset (asynchronous assert, any cycle, mid-stall included):
  - Occupancy goes to 0, `out_valid`=0, `wb_we`=0, `wb_data`=0, `wb_addr`=0, `sel_err`=0, `in_ready`=1.
  - In-flight entries are discarded.
- Outputs other than `out_valid` and `wb_we` are don't-care in value when `out_valid`=0, but reset to 0.

## Structure
- Package `wb_pkg`:
  - `DATA_W` and `ADDR_W` defaults.
  - `ZERO_REG` = 0.
  - Packed struct `wb_entry_t` holding data, addr, we.
- Sub-module `wb_skid_buf`, generic over entry width, provides the two-entry valid/ready buffer.
- `wb_sel_pipe` contains the combinational select, the we qualification, `sel_err`, and one `wb_skid_buf` instance.

## Test plan
- Streaming: `NUM_SRC`=4, `out_ready`=1.
  - Stimulus: sources `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444`; sel 0,1,2,3 on consecutive cycles; addr 8; we=1.
  - Required: `wb_data` sequence 0x1111…, 0x2222…, 0x3333…, 0x4444… one cycle later, `wb_we`=1 each cycle.
- Stall:
  - Stimulus: `out_ready`=0, three valid inputs A, B, C offered back-to-back.
  - Required: A and B accepted, `in_ready`=0 on the third cycle, C held. After `out_ready`=1, the order is A, B, C with no loss.
- Register 0:
  - Stimulus: `in_addr`=0, `in_we`=1, data `0xDEADBEEF`.
  - Required: `out_valid`=1, `wb_we`=0, `wb_data`=`0xDEADBEEF`.
- Out-of-range select:
  - Stimulus: `NUM_SRC`=3, sel=3.
  - Required: `wb_data`=0, `sel_err`=1, and `sel_err` remains 1 after later valid selects.
- Reset mid-stall:
  - Stimulus: occupancy 2, assert `reset_n`=0 between edges.
  - Required: `out_valid`=0, `in_ready`=1, `sel_err`=0 immediately. After release, the first accepted entry appears alone.
